lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/toothless_pkg.sv | 34 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
// Load/store unit types and access-size encodings, shared between the LSU and the decoder.
package toothless_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    localparam logic [1:0] DATA_TYPE_BYTE = 2'b00;
    localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
    localparam logic [1:0] DATA_TYPE_WORD = 2'b10;

    // Type 11 has no legal alignment, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] data_type,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (data_type)
            DATA_TYPE_BYTE: mis = 1'b0;
            DATA_TYPE_HALF: mis = addr_lo[0];
            DATA_TYPE_WORD: mis = (addr_lo != 2'b00);
            default:        mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store-data replication, load extraction.
module lsu_align
    import toothless_pkg::*;
(
    input  logic [1:0]  data_type,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (data_type)
            DATA_TYPE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            DATA_TYPE_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            DATA_TYPE_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign lane = rdata_raw >> {addr_lo, 3'b000};

    always_comb begin
        case (data_type)
            DATA_TYPE_BYTE: rdata_ext = {{24{sign_ext & lane[7]}}, lane[7:0]};
            DATA_TYPE_HALF: rdata_ext = {{16{sign_ext & lane[15]}}, lane[15:0]};
            default:        rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding access on a req/gnt/rvalid memory port, with watchdog.
module lsu_ctrl
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [1:0]            data_type_i,
    input  logic                  data_sign_ext_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [1:0]            err_cause_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic                  mem_err_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output lsu_state_e            dbg_state
);

    // Memory handshake: mem_req_o stays high with stable address/data until a cycle
    // with mem_gnt_i = 1; the single response then comes as a one-cycle mem_rvalid_i.

    localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e            state_q;
    lsu_state_e            state_d;

    logic                  we_q;
    logic [1:0]            type_q;
    logic                  sign_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            wd_cnt_q;

    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    lsu_err_e              cause_q;

    logic                  accept;
    logic                  misaligned;
    logic                  finish;
    logic                  timeout;

    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rdata_ext;

    assign accept     = (state_q == LSU_IDLE) && data_req_i;
    assign misaligned = is_misaligned(data_type_i, addr_i[1:0]);
    assign finish     = (state_q == LSU_WAIT) && mem_rvalid_i;
    assign timeout    = (state_q != LSU_IDLE) && (wd_cnt_q == WD_LAST);

    lsu_align u_align (
        .data_type (type_q),
        .addr_lo   (addr_q[1:0]),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .rdata_raw (mem_rdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response that lands on the watchdog's last cycle still completes the access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept && !misaligned) begin
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (timeout) begin
                    state_d = LSU_IDLE;
                end else if (mem_gnt_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (finish || timeout) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        case (state_q)
            LSU_REQ: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
                mem_be_o    = be;
                mem_wdata_o = wdata_rep;
            end
            LSU_WAIT: begin
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            type_q   <= DATA_TYPE_BYTE;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wd_cnt_q <= 8'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cause_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                we_q     <= data_we_i;
                type_q   <= data_type_i;
                sign_q   <= data_sign_ext_i;
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
                wd_cnt_q <= 8'd0;
                if (misaligned) begin
                    err_q   <= 1'b1;
                    cause_q <= ERR_MISALIGN;
                end else begin
                    cause_q <= ERR_NONE;
                end
            end else if (finish) begin
                if (mem_err_i) begin
                    err_q   <= 1'b1;
                    cause_q <= ERR_BUS;
                end else begin
                    done_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= rdata_ext;
                    end
                end
            end else if (timeout) begin
                err_q   <= 1'b1;
                cause_q <= ERR_TIMEOUT;
            end else if (state_q != LSU_IDLE) begin
                wd_cnt_q <= wd_cnt_q + 8'd1;
            end
        end
    end

    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign err_cause_o = cause_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: two instances (default and short watchdog) against a timeline model.
module tb_lsu_ctrl;
    import toothless_pkg::*;

    localparam int NCYC    = 96;
    localparam int END_CYC = 82;
    localparam int LIMIT0  = 255;
    localparam int LIMIT1  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i, data_we_i, data_sign_ext_i;
    logic [1:0]  data_type_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    logic        o_busy [2];
    logic        o_done [2];
    logic        o_err  [2];
    logic        o_mreq [2];
    logic        o_mwe  [2];
    logic [31:0] o_rdata [2];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mwdata [2];
    logic [1:0]  o_cause [2];
    logic [3:0]  o_be [2];
    lsu_state_e  o_state [2];

    // Stimulus timeline, one entry per cycle.
    bit          drv_rstn [NCYC];
    bit          drv_req  [NCYC];
    bit          drv_we   [NCYC];
    bit [1:0]    drv_typ  [NCYC];
    bit          drv_sgn  [NCYC];
    bit [31:0]   drv_addr [NCYC];
    bit [31:0]   drv_wd   [NCYC];
    bit          drv_gnt  [NCYC];
    bit          drv_rv   [NCYC];
    bit          drv_merr [NCYC];
    bit [31:0]   drv_mrd  [NCYC];

    // Expected outputs per instance per cycle.
    bit          e_busy [2][NCYC];
    bit          e_mreq [2][NCYC];
    bit          e_we   [2][NCYC];
    bit [31:0]   e_addr [2][NCYC];
    bit [3:0]    e_be   [2][NCYC];
    bit [31:0]   e_wdata [2][NCYC];
    bit          e_done [2][NCYC];
    bit          e_err  [2][NCYC];
    bit          e_rd_set [2][NCYC];
    bit [31:0]   e_rd_val [2][NCYC];
    bit          e_cause_set [2][NCYC];
    bit [1:0]    e_cause_val [2][NCYC];
    bit          e_clear [2][NCYC];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_WIDTH(32), .MAX_WAIT(LIMIT0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_type_i(data_type_i),
        .data_sign_ext_i(data_sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(o_busy[0]), .done_o(o_done[0]), .rdata_o(o_rdata[0]),
        .err_o(o_err[0]), .err_cause_o(o_cause[0]),
        .mem_req_o(o_mreq[0]), .mem_we_o(o_mwe[0]), .mem_addr_o(o_maddr[0]),
        .mem_be_o(o_be[0]), .mem_wdata_o(o_mwdata[0]),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i), .dbg_state(o_state[0])
    );

    lsu_ctrl #(.DATA_WIDTH(32), .MAX_WAIT(LIMIT1)) u_dut_wd (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_type_i(data_type_i),
        .data_sign_ext_i(data_sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(o_busy[1]), .done_o(o_done[1]), .rdata_o(o_rdata[1]),
        .err_o(o_err[1]), .err_cause_o(o_cause[1]),
        .mem_req_o(o_mreq[1]), .mem_we_o(o_mwe[1]), .mem_addr_o(o_maddr[1]),
        .mem_be_o(o_be[1]), .mem_wdata_o(o_mwdata[1]),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i), .dbg_state(o_state[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    // Schedule one access accepted in cycle t; gnt arrives gdly cycles into the request,
    // rvalid rdly cycles after the first wait cycle.
    task automatic sched_op(input int t, input bit we, input int typ, input bit sgn,
                            input bit [31:0] addr, input bit [31:0] wd, input int gdly,
                            input int rdly, input bit [31:0] mrd, input bit merr);
        int a, nreq, n, lim, nb;
        bit mis, ok;
        bit [31:0] be, wrep, lane, ld;
        a    = int'(addr % 4);
        mis  = (typ == 3) || (typ == 1 && (a % 2) == 1) || (typ == 2 && a != 0);
        lane = mrd >> (8 * a);
        case (typ)
            0: begin
                be   = 32'd1 << a;
                wrep = (wd & 32'hff) * 32'h01010101;
                ld   = lane & 32'hff;
                if (sgn && ld >= 32'h80) ld = ld - 32'h100;
            end
            1: begin
                be   = 32'd3 << a;
                wrep = (wd & 32'hffff) * 32'h00010001;
                ld   = lane & 32'hffff;
                if (sgn && ld >= 32'h8000) ld = ld - 32'h10000;
            end
            default: begin
                be   = 32'hf;
                wrep = wd;
                ld   = lane;
            end
        endcase
        nreq = gdly + 1;
        n    = nreq + rdly + 1;
        drv_req[t]  = 1'b1;
        drv_we[t]   = we;
        drv_typ[t]  = 2'(typ);
        drv_sgn[t]  = sgn;
        drv_addr[t] = addr;
        drv_wd[t]   = wd;
        if (!mis) begin
            drv_gnt[t + nreq] = 1'b1;
            drv_rv[t + n]     = 1'b1;
            drv_mrd[t + n]    = mrd;
            drv_merr[t + n]   = merr;
        end
        for (int i = 0; i < 2; i++) begin
            lim = (i == 0) ? LIMIT0 : LIMIT1;
            e_cause_set[i][t + 1] = 1'b1;
            e_cause_val[i][t + 1] = mis ? 2'd1 : 2'd0;
            if (mis) begin
                e_err[i][t + 1] = 1'b1;
            end else begin
                ok = (nreq < lim) && (n <= lim);
                nb = ok ? n : lim;
                for (int k = 1; k <= nb; k++) begin
                    e_busy[i][t + k] = 1'b1;
                    if (k <= nreq) begin
                        e_mreq[i][t + k]  = 1'b1;
                        e_we[i][t + k]    = we;
                        e_addr[i][t + k]  = addr & ~32'h3;
                        e_be[i][t + k]    = 4'(be);
                        e_wdata[i][t + k] = wrep;
                    end
                end
                if (!ok) begin
                    e_err[i][t + nb + 1]       = 1'b1;
                    e_cause_set[i][t + nb + 1] = 1'b1;
                    e_cause_val[i][t + nb + 1] = 2'd3;
                end else if (merr) begin
                    e_err[i][t + nb + 1]       = 1'b1;
                    e_cause_set[i][t + nb + 1] = 1'b1;
                    e_cause_val[i][t + nb + 1] = 2'd2;
                end else begin
                    e_done[i][t + nb + 1] = 1'b1;
                    if (!we) begin
                        e_rd_set[i][t + nb + 1] = 1'b1;
                        e_rd_val[i][t + nb + 1] = ld;
                    end
                end
            end
        end
    endtask

    // Reset asserted partway through cycle r: everything from r on is forgotten.
    task automatic sched_rst(input int r);
        drv_rstn[r] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int c = r; c < NCYC; c++) begin
                e_busy[i][c] = 0; e_mreq[i][c] = 0; e_we[i][c] = 0;
                e_addr[i][c] = 0; e_be[i][c] = 0; e_wdata[i][c] = 0;
                e_done[i][c] = 0; e_err[i][c] = 0;
                e_rd_set[i][c] = 0; e_cause_set[i][c] = 0;
            end
            e_clear[i][r] = 1'b1;
        end
    endtask

    task automatic drive(input int c);
        rst_n           = drv_rstn[c];
        data_req_i      = drv_req[c];
        data_we_i       = drv_we[c];
        data_type_i     = drv_typ[c];
        data_sign_ext_i = drv_sgn[c];
        addr_i          = drv_addr[c];
        wdata_i         = drv_wd[c];
        mem_gnt_i       = drv_gnt[c];
        mem_rvalid_i    = drv_rv[c];
        mem_err_i       = drv_merr[c];
        mem_rdata_i     = drv_mrd[c];
    endtask

    initial begin : compare
        bit [31:0] h_rd [2];
        bit [1:0]  h_cause [2];
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < NCYC) begin
                for (int i = 0; i < 2; i++) begin
                    if (e_clear[i][cyc]) begin
                        h_rd[i]    = 32'd0;
                        h_cause[i] = 2'd0;
                    end
                    if (e_cause_set[i][cyc]) h_cause[i] = e_cause_val[i][cyc];
                    if (e_rd_set[i][cyc])    h_rd[i]    = e_rd_val[i][cyc];
                    chk("busy", i, 32'(o_busy[i]), 32'(e_busy[i][cyc]));
                    chk("state_busy", i, 32'(o_state[i] != LSU_IDLE), 32'(e_busy[i][cyc]));
                    chk("mem_req", i, 32'(o_mreq[i]), 32'(e_mreq[i][cyc]));
                    chk("done", i, 32'(o_done[i]), 32'(e_done[i][cyc]));
                    chk("err", i, 32'(o_err[i]), 32'(e_err[i][cyc]));
                    chk("err_cause", i, 32'(o_cause[i]), 32'(h_cause[i]));
                    chk("rdata", i, o_rdata[i], h_rd[i]);
                    if (e_mreq[i][cyc] || !drv_rstn[cyc]) begin
                        chk("mem_we", i, 32'(o_mwe[i]), 32'(e_we[i][cyc]));
                        chk("mem_addr", i, o_maddr[i], e_addr[i][cyc]);
                        chk("mem_be", i, 32'(o_be[i]), 32'(e_be[i][cyc]));
                        chk("mem_wdata", i, o_mwdata[i], e_wdata[i][cyc]);
                    end
                end
                if (cyc == 6) begin
                    chk("pin_ld_addr", 0, o_maddr[0], 32'h0000_0100);
                    chk("pin_ld_be", 0, 32'(o_be[0]), 32'h8);
                end
                if (cyc == 8) begin
                    chk("pin_ld_done", 0, 32'(o_done[0]), 32'h1);
                    chk("pin_ld_rdata", 0, o_rdata[0], 32'hFFFF_FF80);
                end
                if (cyc == 12 || cyc == 14) begin
                    chk("pin_st_be", 0, 32'(o_be[0]), 32'hC);
                    chk("pin_st_wdata", 0, o_mwdata[0], 32'hABCD_ABCD);
                end
                if (cyc == 16) chk("pin_st_done", 0, 32'(o_done[0]), 32'h1);
                if (cyc == 19) begin
                    chk("pin_mis_err", 0, 32'(o_err[0]), 32'h1);
                    chk("pin_mis_cause", 0, 32'(o_cause[0]), 32'h1);
                    chk("pin_mis_noreq", 0, 32'(o_mreq[0]), 32'h0);
                end
                if (cyc == 50) begin
                    chk("pin_wd_err", 1, 32'(o_err[1]), 32'h1);
                    chk("pin_wd_cause", 1, 32'(o_cause[1]), 32'h3);
                end
                if (cyc == 51) chk("pin_wd_noreq", 1, 32'(o_mreq[1]), 32'h0);
                if (cyc == 61) begin
                    chk("pin_rst_busy", 0, 32'(o_busy[0]), 32'h0);
                    chk("pin_rst_req", 0, 32'(o_mreq[0]), 32'h0);
                end
                if (cyc == 71) chk("pin_b2b_rdata", 0, o_rdata[0], 32'hFFFF_9ABC);
            end
        end
    end

    initial begin : stim
        for (int c = 0; c < NCYC; c++) drv_rstn[c] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drv_rstn[c]   = 1'b0;
            e_clear[0][c] = 1'b1;
            e_clear[1][c] = 1'b1;
        end
        //       t   we typ sgn addr          wdata         gdly rdly mem_rdata     merr
        sched_op(5,  0, 0,  1,  32'h0000_0103, 32'h0,        0,   0,   32'h8012_3456, 0);
        sched_op(10, 1, 1,  0,  32'h0000_0022, 32'h1234_ABCD, 3,   0,   32'h0,        0);
        sched_op(18, 0, 2,  0,  32'h0000_0006, 32'h0,        0,   0,   32'h0,        0);
        sched_op(21, 1, 0,  0,  32'h0000_0001, 32'h0000_005A, 0,   1,   32'h0,        1);
        sched_op(27, 0, 1,  0,  32'h0000_0002, 32'h0,        1,   1,   32'hF00D_1234, 0);
        sched_op(34, 0, 1,  1,  32'h0000_0000, 32'h0,        0,   0,   32'h1234_8001, 0);
        sched_op(37, 0, 0,  0,  32'h0000_0041, 32'h0,        0,   0,   32'h0000_FE00, 0);
        sched_op(40, 1, 2,  0,  32'h0000_0044, 32'hDEAD_BEEF, 0,   0,   32'h0,        0);
        sched_op(45, 0, 2,  0,  32'h0000_0080, 32'h0,        6,   0,   32'h1111_2222, 0);
        drv_gnt[56]  = 1'b1;
        drv_rv[56]   = 1'b1;
        drv_merr[56] = 1'b1;
        drv_mrd[56]  = 32'hFFFF_FFFF;
        sched_op(58, 0, 2,  0,  32'h0000_0040, 32'h0,        0,   3,   32'hAAAA_5555, 0);
        sched_rst(61);
        sched_op(65, 0, 0,  1,  32'h0000_0102, 32'h0,        0,   0,   32'h007F_0000, 0);
        sched_op(68, 0, 1,  1,  32'h0000_0012, 32'h0,        0,   0,   32'h9ABC_0000, 0);
        sched_op(73, 0, 3,  0,  32'h0000_0000, 32'h0,        0,   0,   32'h0,        0);

        drive(0);
        while (cyc < END_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            drive(cyc);
        end
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
